// File: rtl/uart_tx_serializer.sv
// Word-buffered UART transmitter: big-endian 16-bit words in, 8 data + parity + stop frames out.
// BUSY paces the upstream reader and holds off a new message until the current one is on the wire.
module uart_tx_serializer #(
    parameter int CLK_FREQ   = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 64,
    parameter int FIFO_AW    = 6
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        ENA,
    input  logic [7:0]  MSG_LEN_IN,
    input  logic        PARITY_IN,
    output logic        TX,
    output logic        BUSY,
    output logic        OVERFLOW
);
    localparam int DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = FIFO_AW + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(DIV - 2);
    localparam logic [CNT_W-1:0] BUSY_LVL = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;

    // FIFO storage and pointers
    logic [15:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [15:0]        rd_data;
    logic               fifo_full, fifo_empty, push, pop;

    // write-side message tracking
    logic               msg_active, msg_active_nxt;
    logic [7:0]         words_left, words_left_nxt, len_words;
    logic               accept, drop, msg_start;

    // transmit side
    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [2:0]         bit_cnt, bit_nxt;
    logic [15:0]        hold, hold_nxt;
    logic               hi, hi_nxt;
    logic [7:0]         bytes_left, bytes_left_nxt, bytes_after;
    logic               par, par_nxt;
    logic               goto_load, stop_done, div_done;
    logic [7:0]         nxt_byte;
    logic               tx_nxt, busy_nxt;

    assign fifo_full  = (count == FULL_LVL);
    assign fifo_empty = (count == '0);
    assign rd_data    = mem[rd_ptr];

    // NOTE: the word store is deliberately not reset; only pointers and count need a known state.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= DATA;
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        len_words      = 8'(({1'b0, MSG_LEN_IN} + 9'd1) >> 1);
        accept         = ENA && !BUSY && !fifo_full;
        drop           = ENA && (BUSY || fifo_full);
        msg_start      = accept && !msg_active && (MSG_LEN_IN != 8'd0);
        push           = msg_start || (accept && msg_active);
        msg_active_nxt = msg_active;
        words_left_nxt = words_left;
        if (msg_start) begin
            words_left_nxt = len_words - 8'd1;
            msg_active_nxt = (len_words != 8'd1);
        end else if (push) begin
            words_left_nxt = words_left - 8'd1;
            msg_active_nxt = (words_left != 8'd1);
        end
    end

    always_comb begin
        state_nxt      = state;
        div_nxt        = div_cnt + DIV_W'(1);
        bit_nxt        = bit_cnt;
        hold_nxt       = hold;
        hi_nxt         = hi;
        pop            = 1'b0;
        par_nxt        = msg_start ? PARITY_IN : par;
        bytes_after    = bytes_left - 8'd1;
        bytes_left_nxt = bytes_left;
        div_done       = (div_cnt == DIV_LAST);
        // the stop bit is cut one cycle short when a LOAD follows, keeping frames gapless
        goto_load      = !hi && (bytes_after != 8'd0);
        stop_done      = div_done || (goto_load && div_cnt == DIV_PRE);

        case (state)
            ST_IDLE: begin
                div_nxt = '0;
                if (bytes_left != 8'd0 && !fifo_empty) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                div_nxt = '0;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    hold_nxt  = rd_data;
                    hi_nxt    = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (div_done) begin
                    div_nxt   = '0;
                    bit_nxt   = 3'd0;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (div_done) begin
                    div_nxt = '0;
                    if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
                    else                 bit_nxt   = bit_cnt + 3'd1;
                end
            end
            ST_PARITY: begin
                if (div_done) begin
                    div_nxt   = '0;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (stop_done) begin
                    div_nxt        = '0;
                    bytes_left_nxt = bytes_after;
                    if (hi && bytes_after != 8'd0) begin
                        hi_nxt    = 1'b0;
                        state_nxt = ST_START;
                    end else if (goto_load) begin
                        state_nxt = ST_LOAD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (msg_start) bytes_left_nxt = MSG_LEN_IN;
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);

        // outputs are registered from next-state values so they line up with the state they describe
        nxt_byte = hi_nxt ? hold_nxt[15:8] : hold_nxt[7:0];
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = nxt_byte[bit_nxt];
            ST_PARITY: tx_nxt = (^nxt_byte) ^ par_nxt;
            default:   tx_nxt = 1'b1;
        endcase
        busy_nxt = (count_nxt >= BUSY_LVL) || (!msg_active_nxt && bytes_left_nxt != 8'd0);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            msg_active <= 1'b0;
            words_left <= '0;
            state      <= ST_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            hold       <= '0;
            hi         <= 1'b0;
            bytes_left <= '0;
            par        <= 1'b0;
            TX         <= 1'b1;
            BUSY       <= 1'b0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            count      <= count_nxt;
            msg_active <= msg_active_nxt;
            words_left <= words_left_nxt;
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            hold       <= hold_nxt;
            hi         <= hi_nxt;
            bytes_left <= bytes_left_nxt;
            par        <= par_nxt;
            TX         <= tx_nxt;
            BUSY       <= busy_nxt;
            OVERFLOW   <= OVERFLOW | drop;
        end
    end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: a line monitor decodes frames, a queue holds expected bytes.
// Baud is raised so every scenario fits a short run; 48 MHz / 3.7 Mbaud = 12.97 rounds to 13 cycles per bit.
module tb_uart_tx_serializer;
    localparam int CLK_FREQ = 48_000_000;
    localparam int BAUD     = 3_700_000;
    localparam int DIV      = 13;
    localparam int FRAME    = 11 * DIV;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [15:0] DATA = '0;
    logic        ENA = 1'b0;
    logic [7:0]  MSG_LEN_IN = '0;
    logic        PARITY_IN = 1'b0;
    logic        TX, BUSY, OVERFLOW;

    uart_tx_serializer #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(64), .FIFO_AW(6)
    ) dut (
        .CLK(CLK), .RST(RST), .DATA(DATA), .ENA(ENA), .MSG_LEN_IN(MSG_LEN_IN),
        .PARITY_IN(PARITY_IN), .TX(TX), .BUSY(BUSY), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] b;
        logic       p;
        logic       s0;
        logic       s1;
        int         t;
    } frame_t;

    typedef struct {
        logic [7:0] b;
        logic       p;
    } exp_t;

    frame_t rx_q[$];
    exp_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    int     ena_cyc = 0;
    int     max_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // line monitor: samples mid-bit, abandons a partial frame on reset
    initial begin : rx_mon
        logic   active;
        int     cnt;
        int     k;
        frame_t f;
        active = 1'b0;
        cnt = 0;
        f = '{b: '0, p: 1'b0, s0: 1'b0, s1: 1'b0, t: 0};
        forever begin
            @(negedge CLK);
            if (RST !== 1'b1) begin
                active = 1'b0;
            end else if (!active) begin
                if (TX === 1'b0) begin
                    active = 1'b1;
                    cnt = 0;
                    f.t = cyc;
                end
            end else begin
                cnt++;
                if (cnt == DIV / 2) begin
                    f.s0 = TX;
                end else if (cnt > DIV / 2 && (cnt - DIV / 2) % DIV == 0) begin
                    k = (cnt - DIV / 2) / DIV;
                    if (k <= 8) f.b[k-1] = TX;
                    else if (k == 9) f.p = TX;
                    else begin
                        f.s1 = TX;
                        rx_q.push_back(f);
                        active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : occ_mon
        forever begin
            @(negedge CLK);
            if (int'(dut.count) > max_cnt) max_cnt = int'(dut.count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d, input logic [7:0] len, input logic p);
        DATA = d;
        MSG_LEN_IN = len;
        PARITY_IN = p;
        ENA = 1'b1;
        tick();
        ena_cyc = cyc;
        ENA = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] b, input logic par);
        exp_t e;
        e.b = b;
        e.p = (^b) ^ par;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] pat(input int j);
        return 8'(j * 37 + 11);
    endfunction

    task automatic check_frames(input string tag, input int n, input int budget, output int first_t);
        frame_t f;
        exp_t   e;
        int     waited;
        int     prev_t;
        waited = 0;
        first_t = -1;
        prev_t = 0;
        while (rx_q.size() < n && waited < budget) begin
            tick();
            waited++;
        end
        chk({tag, " frame count"}, rx_q.size(), n);
        for (int i = 0; i < n && rx_q.size() > 0 && exp_q.size() > 0; i++) begin
            f = rx_q.pop_front();
            e = exp_q.pop_front();
            if (i == 0) first_t = f.t;
            else chk($sformatf("%s gap %0d", tag, i), f.t - prev_t, FRAME);
            chk($sformatf("%s start %0d", tag, i), f.s0, 1'b0);
            chk($sformatf("%s byte %0d", tag, i), f.b, e.b);
            chk($sformatf("%s parity %0d", tag, i), f.p, e.p);
            chk($sformatf("%s stop %0d", tag, i), f.s1, 1'b1);
            prev_t = f.t;
        end
        exp_q.delete();
    endtask

    task automatic wait_busy_low(input int budget, output int fall_t);
        int waited;
        waited = 0;
        fall_t = -1;
        while (BUSY !== 1'b0 && waited < budget) begin
            tick();
            waited++;
        end
        if (BUSY === 1'b0) fall_t = cyc;
    endtask

    initial begin : stim
        int first_t;
        int fall_t;
        int t0;
        int bad;
        int sent;
        int guard;

        // reset state
        repeat (3) tick();
        chk("reset TX", TX, 1'b1);
        chk("reset BUSY", BUSY, 1'b0);
        chk("reset OVERFLOW", OVERFLOW, 1'b0);
        RST = 1'b1;
        tick();

        // 1: len=2, even parity, 0xA55A
        push_exp(8'hA5, 1'b0);
        push_exp(8'h5A, 1'b0);
        send_word(16'hA55A, 8'd2, 1'b0);
        chk("t1 BUSY after write", BUSY, 1'b1);
        check_frames("t1", 2, 3 * FRAME, first_t);
        chk("t1 start latency", first_t - ena_cyc, 2);
        wait_busy_low(2 * FRAME, fall_t);
        chk("t1 BUSY fall", fall_t - first_t, 22 * DIV);

        // 2: len=3, odd parity, low byte of last word dropped
        tick();
        push_exp(8'h01, 1'b1);
        push_exp(8'h02, 1'b1);
        send_word(16'h0102, 8'd3, 1'b1);
        push_exp(8'h03, 1'b1);
        send_word(16'h03FF, 8'd3, 1'b1);
        check_frames("t2", 3, 4 * FRAME, first_t);
        wait_busy_low(2 * FRAME, fall_t);
        chk("t2 BUSY fell", fall_t > 0, 1'b1);
        repeat (2 * FRAME) tick();
        chk("t2 no extra frame", rx_q.size(), 0);

        // 3: second message while BUSY
        push_exp(8'hA5, 1'b0);
        push_exp(8'h5A, 1'b0);
        send_word(16'hA55A, 8'd2, 1'b0);
        repeat (3) tick();
        chk("t3 BUSY held", BUSY, 1'b1);
        send_word(16'h1234, 8'd2, 1'b0);
        chk("t3 OVERFLOW set", OVERFLOW, 1'b1);
        check_frames("t3", 2, 3 * FRAME, first_t);
        wait_busy_low(2 * FRAME, fall_t);
        repeat (2 * FRAME) tick();
        chk("t3 no extra frame", rx_q.size(), 0);

        // 4: zero-length message is discarded
        send_word(16'hBEEF, 8'd0, 1'b0);
        bad = 0;
        for (int i = 0; i < 20000; i++) begin
            if (TX !== 1'b1 || BUSY !== 1'b0) bad++;
            tick();
        end
        chk("t4 line quiet cycles", bad, 0);
        chk("t4 no frame", rx_q.size(), 0);
        chk("t4 OVERFLOW sticky", OVERFLOW, 1'b1);

        // 5: reset in data bit 4 of the first frame
        push_exp(8'hA5, 1'b0);
        push_exp(8'h5A, 1'b0);
        send_word(16'hA55A, 8'd2, 1'b0);
        guard = 0;
        while (TX !== 1'b0 && guard < 10) begin
            tick();
            guard++;
        end
        t0 = cyc;
        chk("t5 frame began", TX, 1'b0);
        repeat (5 * DIV + DIV / 2) tick();
        chk("t5 data bit 4 before reset", TX, 1'b0);
        RST = 1'b0;
        #1;
        chk("t5 TX in reset", TX, 1'b1);
        chk("t5 BUSY in reset", BUSY, 1'b0);
        chk("t5 OVERFLOW in reset", OVERFLOW, 1'b0);
        exp_q.delete();
        rx_q.delete();
        repeat (3) tick();
        RST = 1'b1;
        tick();
        push_exp(8'hA5, 1'b0);
        push_exp(8'h5A, 1'b0);
        send_word(16'hA55A, 8'd2, 1'b0);
        check_frames("t5", 2, 3 * FRAME, first_t);
        chk("t5 start latency", first_t - ena_cyc, 2);
        wait_busy_low(2 * FRAME, fall_t);
        chk("t5 BUSY fall", fall_t - first_t, 22 * DIV);
        chk("t5 start offset", t0 > 0, 1'b1);

        // 6: len=255 streamed under BUSY backpressure
        tick();
        max_cnt = 0;
        sent = 0;
        guard = 0;
        while (sent < 128 && guard < 60000) begin
            if (BUSY === 1'b0) begin
                DATA = {pat(2 * sent), pat(2 * sent + 1)};
                MSG_LEN_IN = 8'd255;
                PARITY_IN = 1'b1;
                ENA = 1'b1;
                push_exp(pat(2 * sent), 1'b1);
                if (2 * sent + 1 < 255) push_exp(pat(2 * sent + 1), 1'b1);
                sent++;
            end else begin
                ENA = 1'b0;
            end
            tick();
            guard++;
        end
        ENA = 1'b0;
        chk("t6 words written", sent, 128);
        check_frames("t6", 255, 256 * FRAME, first_t);
        chk("t6 OVERFLOW clear", OVERFLOW, 1'b0);
        chk("t6 FIFO bound", max_cnt <= 64, 1'b1);
        wait_busy_low(2 * FRAME, fall_t);
        chk("t6 BUSY fell", fall_t > 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
